// File: rtl/apb_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : apb_master_if
// Description : Bundles the command/response request port and the APB bus
//               of the APB requester.
//               master modport : view taken by apb_master (drives APB, rsp_*)
//               slave modport  : view taken by the initiator/peripheral side
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : single-transfer command
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout          : completion strobe + status
//   paddr/psel/penable/pwrite/pwdata/prdata/pready/pslvrr : APB bus
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslvrr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslvrr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslvrr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : apb_master
// Description : APB requester. Converts single valid/ready commands into APB
//               SETUP/ACCESS sequences, returns read data and error status on
//               a one-cycle rsp_valid strobe, and aborts transfers whose
//               ACCESS phase sees pready low for TIMEOUT cycles.
// Ports       : pclk   - bus clock, rising edge
//               preset - asynchronous active-low reset
//               bus    - apb_master_if.master (command, response, APB bus)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic          pclk,
  input  logic          preset,
  apb_master_if.master  bus
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT);
  // Abort happens when the counter reaches this value, so it never wraps.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.cmd_ready   <= 1'b1;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= {ADDR_WIDTH{1'b0}};
      bus.pwdata      <= {DATA_WIDTH{1'b0}};
      bus.rsp_valid   <= 1'b0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.rsp_rdata   <= {DATA_WIDTH{1'b0}};
    end else begin
      // Completion strobe lasts exactly one cycle; status fields hold.
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            // pwdata is loaded on reads too; the slave ignores it.
            bus.pwrite    <= bus.cmd_write;
            bus.paddr     <= bus.cmd_addr;
            bus.pwdata    <= bus.cmd_wdata;
            bus.psel      <= 1'b1;
            bus.penable   <= 1'b0;
            bus.cmd_ready <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          wait_cnt    <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so it wins over a coincident timeout.
          if (bus.pready) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= bus.pslvrr;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_rdata   <= bus.pwrite ? {DATA_WIDTH{1'b0}} : bus.prdata;
            state           <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_rdata   <= {DATA_WIDTH{1'b0}};
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to an idle, deselected bus.
          bus.psel      <= 1'b0;
          bus.penable   <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_apb_master
// Description : Directed self-checking bench for apb_master. A small word
//               memory acts as the APB slave data store; pready/pslvrr are
//               driven per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

  logic pclk;
  logic preset;
  int   total;
  int   bad;

  apb_master_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  apb_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave data store: writes land on a successful ACCESS edge.
  logic [31:0] mem [0:63];
  assign bus.prdata = mem[bus.paddr];
  always @(posedge pclk) begin
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslvrr)
      mem[bus.paddr] <= bus.pwdata;
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset;
    preset = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.pready = 1'b0; bus.pslvrr = 1'b0;
    repeat (2) tick();
    total++; if (bus.psel !== 1'b0) begin bad++; $display("FAIL rst_psel: got %b expected 0", bus.psel); end
    total++; if (bus.penable !== 1'b0) begin bad++; $display("FAIL rst_penable: got %b expected 0", bus.penable); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    total++; if (bus.paddr !== 6'h00) begin bad++; $display("FAIL rst_paddr: got %h expected 00", bus.paddr); end
    total++; if (bus.pwdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata: got %h expected 0", bus.pwdata); end
    total++; if ({bus.rsp_err, bus.rsp_timeout, bus.pwrite} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b expected 000", {bus.rsp_err, bus.rsp_timeout, bus.pwrite}); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h expected 0", bus.rsp_rdata); end
    preset = 1'b1;
    tick();
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b expected 1", bus.cmd_ready); end
    total++; if (bus.psel !== 1'b0) begin bad++; $display("FAIL rst_idle_psel: got %b expected 0", bus.psel); end
  endtask

  task automatic test_write_zero_wait;
    bus.pready = 1'b1; bus.pslvrr = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h00; bus.cmd_wdata = 32'hDEADBEEF;
    tick(); // E0: SETUP
    bus.cmd_valid = 1'b0;
    total++; if ({bus.psel, bus.penable} !== 2'b10) begin bad++; $display("FAIL wr_setup: got psel/penable %b expected 10", {bus.psel, bus.penable}); end
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL wr_setup_ready: got %b expected 0", bus.cmd_ready); end
    total++; if (bus.pwrite !== 1'b1) begin bad++; $display("FAIL wr_pwrite: got %b expected 1", bus.pwrite); end
    tick(); // E1: ACCESS
    total++; if ({bus.psel, bus.penable} !== 2'b11) begin bad++; $display("FAIL wr_access: got psel/penable %b expected 11", {bus.psel, bus.penable}); end
    total++; if (bus.paddr !== 6'h00) begin bad++; $display("FAIL wr_paddr: got %h expected 00", bus.paddr); end
    total++; if (bus.pwdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_pwdata: got %h expected deadbeef", bus.pwdata); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp: got %b expected 0", bus.rsp_valid); end
    tick(); // E2: completion
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_rsp_valid: got %b expected 1", bus.rsp_valid); end
    total++; if ({bus.psel, bus.penable} !== 2'b00) begin bad++; $display("FAIL wr_done_bus: got %b expected 00", {bus.psel, bus.penable}); end
    total++; if ({bus.rsp_err, bus.rsp_timeout} !== 2'b00) begin bad++; $display("FAIL wr_rsp_status: got %b expected 00", {bus.rsp_err, bus.rsp_timeout}); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp_rdata: got %h expected 0", bus.rsp_rdata); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_one_cycle: got %b expected 0", bus.rsp_valid); end
    total++; if (bus.paddr !== 6'h00 || bus.pwdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_idle_hold: got %h/%h expected 00/deadbeef", bus.paddr, bus.pwdata); end
  endtask

  task automatic test_read_waits;
    bus.pready = 1'b0; bus.pslvrr = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 6'h00; bus.cmd_wdata = 32'h1111_2222;
    tick(); // E0
    bus.cmd_valid = 1'b0;
    total++; if (bus.pwrite !== 1'b0) begin bad++; $display("FAIL rd_pwrite: got %b expected 0", bus.pwrite); end
    total++; if (bus.pwdata !== 32'h1111_2222) begin bad++; $display("FAIL rd_pwdata_loaded: got %h expected 11112222", bus.pwdata); end
    tick(); // E1: first ACCESS cycle
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin bad++; $display("FAIL rd_wait%0d: got psel/penable/rsp %b expected 110", i, {bus.psel, bus.penable, bus.rsp_valid}); end
    end
    bus.pready = 1'b1;
    tick(); // E5
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid: got %b expected 1", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata: got %h expected deadbeef", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rd_err: got %b expected 0", bus.rsp_err); end
    tick();
    total++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata_hold: got %h expected deadbeef", bus.rsp_rdata); end
  endtask

  task automatic test_slave_error;
    bus.pready = 1'b1; bus.pslvrr = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h3F; bus.cmd_wdata = 32'h1234_5678;
    tick();
    bus.cmd_valid = 1'b0;
    total++; if (bus.paddr !== 6'h3F) begin bad++; $display("FAIL err_paddr: got %h expected 3f", bus.paddr); end
    repeat (2) tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL err_rsp_valid: got %b expected 1", bus.rsp_valid); end
    total++; if ({bus.rsp_err, bus.rsp_timeout} !== 2'b10) begin bad++; $display("FAIL err_status: got %b expected 10", {bus.rsp_err, bus.rsp_timeout}); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL err_rdata: got %h expected 0", bus.rsp_rdata); end
    bus.pslvrr = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    bus.pready = 1'b1; bus.pslvrr = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h05; bus.cmd_wdata = 32'hA5A5_5A5A;
    tick(); // E0 accept first
    bus.cmd_addr = 6'h06; bus.cmd_wdata = 32'h0BAD_F00D;
    total++; if ({bus.psel, bus.cmd_ready} !== 2'b10) begin bad++; $display("FAIL b2b_setup1: got psel/ready %b expected 10", {bus.psel, bus.cmd_ready}); end
    tick(); // E1
    total++; if ({bus.psel, bus.penable, bus.cmd_ready} !== 3'b110) begin bad++; $display("FAIL b2b_access1: got %b expected 110", {bus.psel, bus.penable, bus.cmd_ready}); end
    tick(); // E2 complete first
    total++; if ({bus.psel, bus.rsp_valid, bus.cmd_ready} !== 3'b011) begin bad++; $display("FAIL b2b_gap: got psel/rsp/ready %b expected 011", {bus.psel, bus.rsp_valid, bus.cmd_ready}); end
    tick(); // E3 accept second
    bus.cmd_valid = 1'b0;
    total++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b100) begin bad++; $display("FAIL b2b_setup2: got %b expected 100", {bus.psel, bus.penable, bus.rsp_valid}); end
    total++; if (bus.paddr !== 6'h06 || bus.pwdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL b2b_cmd2: got %h/%h expected 06/0badf00d", bus.paddr, bus.pwdata); end
    tick();
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_rsp2: got %b expected 1", bus.rsp_valid); end
    tick();
  endtask

  task automatic test_timeout;
    // Full timeout, then the same read with pready rising in the 16th ACCESS cycle.
    for (int run = 0; run < 2; run++) begin
      bus.pready = 1'b0; bus.pslvrr = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 6'h05; bus.cmd_wdata = 32'h0;
      tick(); // E0
      bus.cmd_valid = 1'b0;
      tick(); // E1
      for (int i = 0; i < 15; i++) tick();
      total++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) begin bad++; $display("FAIL to%0d_still_waiting: got %b expected 110", run, {bus.psel, bus.penable, bus.rsp_valid}); end
      if (run == 1) bus.pready = 1'b1;
      tick(); // E1+16
      total++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b001) begin bad++; $display("FAIL to%0d_done: got %b expected 001", run, {bus.psel, bus.penable, bus.rsp_valid}); end
      if (run == 0) begin
        total++; if ({bus.rsp_err, bus.rsp_timeout} !== 2'b11) begin bad++; $display("FAIL to_status: got %b expected 11", {bus.rsp_err, bus.rsp_timeout}); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h expected 0", bus.rsp_rdata); end
      end else begin
        total++; if ({bus.rsp_err, bus.rsp_timeout} !== 2'b00) begin bad++; $display("FAIL late_ready_status: got %b expected 00", {bus.rsp_err, bus.rsp_timeout}); end
        total++; if (bus.rsp_rdata !== 32'hA5A5_5A5A) begin bad++; $display("FAIL late_ready_rdata: got %h expected a5a55a5a", bus.rsp_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset;
    bus.pready = 1'b0; bus.pslvrr = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 6'h06; bus.cmd_wdata = 32'h0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick(); // in ACCESS, waiting
    #3 preset = 1'b0;
    #1;
    total++; if ({bus.psel, bus.penable} !== 2'b00) begin bad++; $display("FAIL arst_bus: got %b expected 00", {bus.psel, bus.penable}); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL arst_rdata: got %h expected 0", bus.rsp_rdata); end
    bus.pready = 1'b1;
    repeat (2) begin
      tick();
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL arst_no_rsp: got %b expected 0", bus.rsp_valid); end
    end
    preset = 1'b1;
    tick();
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL arst_ready: got %b expected 1", bus.cmd_ready); end
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (2) tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL arst_read_valid: got %b expected 1", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL arst_read_rdata: got %h expected 0badf00d", bus.rsp_rdata); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_error();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master.md
# apb_master

APB requester (master) for the peripheral bus: it turns single-transfer commands from an internal valid/ready request port into APB SETUP/ACCESS sequences toward `apb_slave`. It waits on `pready`, returns read data and error status on a one-cycle response strobe, and aborts transfers that stall too long. It is the RTL counterpart of the bus-driving sequences currently hand-coded in the slave bench, and it is the bus-side bridge for any on-chip initiator.

## Interface
Parameters:
- ADDR_WIDTH, 6, width of `paddr`/`cmd_addr`
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT, 16, max ACCESS cycles with `pready` low before abort (≥2)

Ports:
- pclk  in  1  bus clock; all logic on rising edge
- preset  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
- rsp_err  out  1  `pslvrr` sampled at completion, or timeout
- rsp_timeout  out  1  completion was a timeout abort
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslvrr  in  1  APB slave error

## Operation
- FSM: IDLE, SETUP, ACCESS. All outputs registered; `cmd_ready` = (state==IDLE).
- IDLE: on `cmd_valid` -> latch cmd_write/addr/wdata into pwrite/paddr/pwdata, psel=1, penable=0, go SETUP. Else hold.
- SETUP: unconditionally -> ACCESS, penable=1, wait counter cleared to 0.
- ACCESS, `pready`=1: -> IDLE; psel=penable=0; rsp_valid=1; rsp_err=pslvrr; rsp_timeout=0; rsp_rdata=prdata if read, else 0.
- ACCESS, `pready`=0, counter < TIMEOUT-1: stay, counter+1.
- ACCESS, `pready`=0, counter == TIMEOUT-1: abort -> IDLE; psel=penable=0; rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- `pready` wins over timeout on the same edge.
- paddr/pwrite/pwdata stable from SETUP through ACCESS; hold last values in IDLE.
- pwdata loaded on reads too (don't-care to slave).
- Counter width $clog2(TIMEOUT); no wrap possible since abort at TIMEOUT-1.
- No command buffering: commands presented while not IDLE wait (cmd_ready=0).

## Timing
- Reset (preset=0, async): state IDLE, counter 0, psel/penable/pwrite=0, paddr=0, pwdata=0, rsp_valid/err/timeout=0, rsp_rdata=0; cmd_ready=1 after reset release. Reset mid-transfer drops psel/penable immediately; no response issued.
- Accept at edge E0 -> SETUP visible after E0; ACCESS after E1; zero-wait slave (pready=1 during first ACCESS) completes at E2: rsp_valid high for the cycle after E2.
- Latency = 3 edges + wait states; N wait states -> rsp_valid after E2+N.
- rsp_valid is exactly one cycle; rsp_rdata/err/timeout hold until next completion.
- Back-to-back: cmd_ready high in the cycle rsp_valid is high; new accept there -> SETUP one cycle later; psel low exactly one cycle between transfers.
- Timeout: pready low through TIMEOUT ACCESS cycles -> abort at edge E1+TIMEOUT.

## Test plan
- Write zero-wait: cmd write addr 0x00 data 0xDEADBEEF -> psel 1 cycle SETUP, 1 cycle ACCESS with paddr=0, pwdata=0xDEADBEEF; rsp_valid one cycle, rsp_err=0, rsp_rdata=0.
- Read back with 3 wait states: cmd read addr 0x00, pready low 3 ACCESS cycles -> ACCESS lasts 4 cycles, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Slave error: write to addr 0x3F, slave returns pready=1, pslvrr=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: pready held 0 -> after 16 ACCESS cycles psel=0, rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready rising on cycle 16 instead -> normal completion.
- Back-to-back: cmd_valid held high with two commands -> psel low exactly one cycle between them; cmd_ready low during SETUP/ACCESS.
- Async reset during ACCESS: assert preset=0 between edges -> psel/penable 0 immediately, no rsp_valid; after release, a new read completes normally.
